// File: rtl/serial_mem_responder.sv
// Memory-side end of the CPU serial link: decodes READ16/WRITE16 commands, queues read replies.
// Optional macro ROM_PROTECT_EN: serial writes to word index < ROM_WORDS leave RAM unchanged.
module serial_mem_responder #(
   parameter int unsigned IO_BITS        = 2,
   parameter int unsigned PAYLOAD_CYCLES = 8,
   parameter int unsigned MEM_AW         = 8,
   parameter int unsigned RQ_DEPTH       = 4,
   parameter int unsigned RESP_DELAY     = 2,
   parameter int unsigned ROM_WORDS      = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [IO_BITS-1:0] cmd_pins,
   output logic [IO_BITS-1:0] resp_pins,
   input  logic               host_we,
   input  logic [MEM_AW-1:0]  host_addr,
   input  logic [15:0]        host_wdata,
   output logic [15:0]        host_rdata,
   output logic               overflow,
   output logic               busy
);

   localparam int unsigned WORD_W    = 16;
   localparam int unsigned SR_W      = WORD_W - IO_BITS;
   localparam int unsigned CYC_W     = (PAYLOAD_CYCLES > 1) ? $clog2(PAYLOAD_CYCLES) : 1;
   localparam int unsigned PTR_W     = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
   localparam int unsigned CNT_W     = $clog2(RQ_DEPTH + 1);
   localparam int unsigned TMAX      = (RESP_DELAY > PAYLOAD_CYCLES) ? RESP_DELAY : PAYLOAD_CYCLES;
   localparam int unsigned TCNT_W    = $clog2(TMAX + 1);
   localparam int unsigned MEM_WORDS = 2 ** MEM_AW;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
   typedef enum logic [2:0] {T_IDLE, T_WAIT, T_START, T_DATA, T_GAP} t_state_e;

   logic [WORD_W-1:0] mem [MEM_WORDS];
   logic [WORD_W-1:0] rq_mem [RQ_DEPTH];

   r_state_e          r_state, r_state_d;
   logic [CYC_W-1:0]  r_cnt, r_cnt_d;
   logic [IO_BITS-1:0] r_hdr, r_hdr_d;
   logic [SR_W-1:0]   r_sr, r_sr_d;
   logic [MEM_AW-1:0] r_word, r_word_d;
   logic [WORD_W-1:0] rx_word;
   logic              rd_done, wr_done, wr_allow;
   logic [WORD_W-1:0] rd_data;

   t_state_e          t_state, t_state_d;
   logic [TCNT_W-1:0] t_cnt, t_cnt_d;
   logic [WORD_W-1:0] tx_sr, tx_sr_d;
   logic [IO_BITS-1:0] resp_d;
   logic              pop;

   logic [PTR_W-1:0]  rq_wr, rq_rd;
   logic [CNT_W-1:0]  rq_count, rq_count_d;
   logic              push_ok, drop, busy_d;

   assign rx_word    = {cmd_pins, r_sr};
   assign rd_data    = mem[rx_word[MEM_AW:1]];
   assign host_rdata = mem[host_addr];

`ifdef ROM_PROTECT_EN
   assign wr_allow = 32'(r_word) >= ROM_WORDS;
`else
   assign wr_allow = 1'b1;
`endif

   // Receiver: header, address payload, optional data payload
   always_comb begin
      r_state_d = r_state;
      r_cnt_d   = r_cnt;
      r_hdr_d   = r_hdr;
      r_sr_d    = r_sr;
      r_word_d  = r_word;
      rd_done   = 1'b0;
      wr_done   = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (cmd_pins != '0) begin
               r_state_d = R_ADDR;
               r_hdr_d   = cmd_pins;
               r_cnt_d   = '0;
            end
         end
         R_ADDR: begin
            r_sr_d  = rx_word[WORD_W-1:IO_BITS];
            r_cnt_d = r_cnt + CYC_W'(1);
            if (r_cnt == CYC_W'(PAYLOAD_CYCLES - 1)) begin
               r_cnt_d  = '0;
               r_word_d = rx_word[MEM_AW:1];
               if (r_hdr == IO_BITS'(2)) begin
                  r_state_d = R_DATA;
               end else begin
                  r_state_d = R_IDLE;
                  rd_done   = (r_hdr == IO_BITS'(1));
               end
            end
         end
         R_DATA: begin
            r_sr_d  = rx_word[WORD_W-1:IO_BITS];
            r_cnt_d = r_cnt + CYC_W'(1);
            if (r_cnt == CYC_W'(PAYLOAD_CYCLES - 1)) begin
               r_cnt_d   = '0;
               r_state_d = R_IDLE;
               wr_done   = 1'b1;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      if (!reset) begin
         rd_done = 1'b0;
         wr_done = 1'b0;
      end
   end

   // Transmitter: delay, start symbol, payload, one idle gap
   always_comb begin
      t_state_d = t_state;
      t_cnt_d   = t_cnt;
      tx_sr_d   = tx_sr;
      pop       = 1'b0;
      case (t_state)
         T_IDLE: begin
            if (rq_count != '0) begin
               t_cnt_d = '0;
               if (RESP_DELAY == 0) begin
                  t_state_d = T_START;
                  pop       = 1'b1;
               end else begin
                  t_state_d = T_WAIT;
               end
            end
         end
         T_WAIT: begin
            t_cnt_d = t_cnt + TCNT_W'(1);
            if (t_cnt == TCNT_W'(RESP_DELAY - 1)) begin
               t_state_d = T_START;
               pop       = 1'b1;
            end
         end
         T_START: begin
            t_state_d = T_DATA;
            t_cnt_d   = '0;
         end
         T_DATA: begin
            tx_sr_d = tx_sr >> IO_BITS;
            t_cnt_d = t_cnt + TCNT_W'(1);
            if (t_cnt == TCNT_W'(PAYLOAD_CYCLES - 1)) t_state_d = T_GAP;
         end
         T_GAP:   t_state_d = T_IDLE;
         default: t_state_d = T_IDLE;
      endcase
      if (pop) tx_sr_d = rq_mem[rq_rd];
      resp_d = '0;
      if (t_state_d == T_START)     resp_d = IO_BITS'(1);
      else if (t_state_d == T_DATA) resp_d = tx_sr_d[IO_BITS-1:0];
   end

   // Reply queue occupancy; a push into a full queue survives only alongside a pop
   always_comb begin
      push_ok    = rd_done && ((rq_count != CNT_W'(RQ_DEPTH)) || pop);
      drop       = rd_done && !push_ok;
      rq_count_d = rq_count;
      if (push_ok && !pop)      rq_count_d = rq_count + CNT_W'(1);
      else if (!push_ok && pop) rq_count_d = rq_count - CNT_W'(1);
      busy_d = (r_state_d != R_IDLE) || (rq_count_d != '0) || (t_state_d != T_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= R_IDLE;
         r_cnt     <= '0;
         r_hdr     <= '0;
         r_sr      <= '0;
         r_word    <= '0;
         t_state   <= T_IDLE;
         t_cnt     <= '0;
         tx_sr     <= '0;
         resp_pins <= '0;
         rq_wr     <= '0;
         rq_rd     <= '0;
         rq_count  <= '0;
         overflow  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         r_state   <= r_state_d;
         r_cnt     <= r_cnt_d;
         r_hdr     <= r_hdr_d;
         r_sr      <= r_sr_d;
         r_word    <= r_word_d;
         t_state   <= t_state_d;
         t_cnt     <= t_cnt_d;
         tx_sr     <= tx_sr_d;
         resp_pins <= resp_d;
         rq_count  <= rq_count_d;
         busy      <= busy_d;
         if (push_ok) rq_wr <= (rq_wr == PTR_W'(RQ_DEPTH - 1)) ? '0 : rq_wr + PTR_W'(1);
         if (pop)     rq_rd <= (rq_rd == PTR_W'(RQ_DEPTH - 1)) ? '0 : rq_rd + PTR_W'(1);
         if (drop)    overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) rq_mem[rq_wr] <= rd_data;
   end

   // Serial write is placed last so it wins a same-word collision with the host port
   always_ff @(posedge clk) begin
      if (host_we)              mem[host_addr] <= host_wdata;
      if (wr_done && wr_allow)  mem[r_word]    <= rx_word;
   end

endmodule

// File: tb/tb_serial_mem_responder.sv
// Randomized scoreboard bench for serial_mem_responder with a word-level reference model.
module tb_serial_mem_responder;

   localparam int unsigned IO_BITS    = 2;
   localparam int unsigned MEM_AW     = 8;
   localparam int unsigned RQ_DEPTH   = 4;
   localparam int unsigned RESP_DELAY = 40;
   localparam int unsigned ROM_WORDS  = 16;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic [IO_BITS-1:0] cmd_pins = '0;
   logic [IO_BITS-1:0] resp_pins;
   logic               host_we = 1'b0;
   logic [MEM_AW-1:0]  host_addr = '0;
   logic [15:0]        host_wdata = '0;
   logic [15:0]        host_rdata;
   logic               overflow;
   logic               busy;

   serial_mem_responder #(
      .IO_BITS(IO_BITS), .PAYLOAD_CYCLES(8), .MEM_AW(MEM_AW),
      .RQ_DEPTH(RQ_DEPTH), .RESP_DELAY(RESP_DELAY), .ROM_WORDS(ROM_WORDS)
   ) dut (
      .clk(clk), .reset(reset), .cmd_pins(cmd_pins), .resp_pins(resp_pins),
      .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(host_rdata), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] model_ram [256];
   int          pushed = 0;
   int          started = 0;
   int          replies = 0;
   int unsigned start_cyc = 0;
   logic [15:0] mon_w;
   logic [15:0] mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit rom_hit(input logic [7:0] w);
`ifdef ROM_PROTECT_EN
      return 32'(w) < ROM_WORDS;
`else
      return w != w;
`endif
   endfunction

   // Drives one message; t_last is the cycle number of the last address cycle
   task automatic send_msg(input logic [1:0] hdr, input logic [15:0] addr, input logic [15:0] data,
                           input bit collide, input bit chk_busy, output int unsigned t_last);
      cmd_pins = hdr;
      tick();
      for (int i = 0; i < 8; i++) begin
         cmd_pins = addr[2*i +: 2];
         if (i == 7) t_last = cyc;
         if (chk_busy && i == 1) begin
            @(negedge clk);
            check("busy_during_cmd", 32'(busy), 32'd1);
         end
         tick();
      end
      if (hdr == 2'b10) begin
         for (int i = 0; i < 8; i++) begin
            cmd_pins = data[2*i +: 2];
            if (collide && i == 7) begin
               host_we    = 1'b1;
               host_addr  = addr[8:1];
               host_wdata = ~data;
            end
            tick();
         end
         host_we = 1'b0;
      end
      cmd_pins = '0;
   endtask

   task automatic do_read(input logic [15:0] addr, input bit flow, output int unsigned t_last);
      logic [7:0] w;
      w = addr[8:1];
      if (flow) begin
         for (int i = 0; i < 3000 && (pushed - started) >= int'(RQ_DEPTH); i++) tick();
         if ((pushed - started) >= int'(RQ_DEPTH)) check("queue_space_timeout", 32'(pushed - started), 32'(RQ_DEPTH - 1));
      end
      exp_q.push_back(model_ram[w]);
      pushed++;
      send_msg(2'b01, addr, 16'h0, 1'b0, 1'b0, t_last);
   endtask

   task automatic do_write(input logic [15:0] addr, input logic [15:0] data, input bit collide);
      logic [7:0]  w;
      int unsigned t;
      w = addr[8:1];
      send_msg(2'b10, addr, data, collide, 1'b0, t);
      if (!rom_hit(w))  model_ram[w] = data;
      else if (collide) model_ram[w] = ~data;
   endtask

   task automatic wait_drain(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 5000 && !done; i++) begin
         if (exp_q.size() == 0 && !busy) done = 1'b1;
         else tick();
      end
      check(name, 32'(done), 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Monitor: assembles each reply and compares with the scoreboard head
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (reset && resp_pins != '0) begin
            if (resp_pins != 2'b01) begin
               check("stray_resp_pins", 32'(resp_pins), 32'd1);
            end else begin
               start_cyc = cyc;
               started++;
               mon_w = '0;
               for (int i = 0; i < 8; i++) begin
                  @(negedge clk);
                  mon_w[2*i +: 2] = resp_pins;
               end
               @(negedge clk);
               check("gap_after_reply", 32'(resp_pins), 32'd0);
               if (exp_q.size() == 0) begin
                  check("unexpected_reply", 32'(mon_w), 32'hFFFF_FFFF);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("reply_data", 32'(mon_w), 32'(mon_e));
               end
               replies++;
            end
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int unsigned t;
      int          r0;
      logic [15:0] a, d;
      int          kind;

      cmd_pins = '0;
      reset    = 1'b0;
      idle(3);
      @(negedge clk);
      check("reset_resp_pins", 32'(resp_pins), 32'd0);
      check("reset_overflow", 32'(overflow), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Preload every word so the model knows the full RAM image
      for (int i = 0; i < 256; i++) begin
         model_ram[i] = 16'($urandom);
         if (i == 5) model_ram[i] = 16'hBEEF;
         if (i == 3) model_ram[i] = 16'h0001;
         host_we    = 1'b1;
         host_addr  = 8'(i);
         host_wdata = model_ram[i];
         tick();
      end
      host_we   = 1'b0;
      host_addr = 8'd5;
      #1;
      check("host_rdata_preload", 32'(host_rdata), 32'hBEEF);

      // Read of a preloaded word from an idle link, including reply latency
      do_read(16'h000A, 1'b0, t);
      wait_drain("drain_read_beef");
      check("reply_latency", 32'(start_cyc), 32'(t + 2 + RESP_DELAY));

      // Write with a same-cycle host write to the same word, then read back
      do_write(16'h0010, 16'h1234, 1'b1);
      do_read(16'h0010, 1'b1, t);
      wait_drain("drain_write_read");
      host_addr = 8'd8;
      #1;
      check("host_rdata_word8", 32'(host_rdata), 32'(model_ram[8]));

      // Queued reply keeps its snapshot despite an immediate overwrite
      do_read(16'h0006, 1'b1, t);
      do_write(16'h0006, 16'h5555, 1'b0);
      wait_drain("drain_snapshot");
      host_addr = 8'd3;
      #1;
      check("host_rdata_word3", 32'(host_rdata), 32'h5555);

      // Low word write (ROM-protected only when the macro is defined)
      do_write(16'h0004, 16'hFFFF, 1'b0);
      do_read(16'h0004, 1'b1, t);
      wait_drain("drain_rom");

      // Five back-to-back reads: queue fills before the first pop, fifth is dropped
      r0 = replies;
      for (int i = 0; i < 5; i++) begin
         a = 16'($urandom);
         if (i < 4) begin
            exp_q.push_back(model_ram[a[8:1]]);
            pushed++;
         end
         send_msg(2'b01, a, 16'h0, 1'b0, (i == 0), t);
      end
      wait_drain("drain_overflow");
      idle(100);
      check("overflow_reply_count", 32'(replies - r0), 32'd4);
      check("overflow_flag", 32'(overflow), 32'd1);

      // Reset in the middle of an address payload aborts the message
      cmd_pins = 2'b01;
      tick();
      for (int i = 0; i < 3; i++) begin
         cmd_pins = 2'(i + 1);
         tick();
      end
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cmd_pins = 2'($urandom_range(1, 3));
         tick();
      end
      cmd_pins = '0;
      reset    = 1'b1;
      @(negedge clk);
      check("post_reset_overflow", 32'(overflow), 32'd0);
      check("post_reset_busy", 32'(busy), 32'd0);
      check("post_reset_resp", 32'(resp_pins), 32'd0);
      @(posedge clk); #1;
      r0 = replies;
      do_read(16'h0000, 1'b1, t);
      wait_drain("drain_after_reset");
      idle(100);
      check("after_reset_reply_count", 32'(replies - r0), 32'd1);
      check("after_reset_overflow", 32'(overflow), 32'd0);

      // Random mix of reads, writes, reserved commands and host writes in gaps
      for (int n = 0; n < 60; n++) begin
         kind = int'($urandom_range(0, 9));
         a    = 16'($urandom);
         d    = 16'($urandom);
         if (kind < 5)      do_read(a, 1'b1, t);
         else if (kind < 9) do_write(a, d, 1'b0);
         else               send_msg(2'b11, a, 16'h0, 1'b0, 1'b0, t);
         for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
            if ($urandom_range(0, 3) == 0) begin
               host_we    = 1'b1;
               host_addr  = 8'($urandom);
               host_wdata = 16'($urandom);
               model_ram[host_addr] = host_wdata;
            end
            tick();
            host_we = 1'b0;
         end
      end
      wait_drain("drain_random");
      check("final_overflow", 32'(overflow), 32'd0);
      check("final_reply_count", 32'(replies), 32'(pushed));

      for (int i = 0; i < 16; i++) begin
         host_addr = 8'($urandom);
         #1;
         check("host_rdata_final", 32'(host_rdata), 32'(model_ram[host_addr]));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
